// File: rtl/i2c_slave_mem.sv
// I2C target with a small byte memory: address byte, word-pointer byte, then
// data bytes with pointer auto-increment (EEPROM style). No clock stretching.
`timescale 1ns/1ps
module i2c_slave_mem #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned MEM_AW     = 4,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic              sysclk_i,
   input  logic              reset_n_i,
   inout  wire               scl_pin,
   inout  wire               sda_pin,
   input  logic [MEM_AW-1:0] dbg_addr_i,
   output logic [7:0]        dbg_data_o,
   output logic              busy_o,
   output logic              sel_o,
   output logic              wr_stb_o,
   output logic [MEM_AW-1:0] ptr_o
);
   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] CNT_MAX = FW'(FILTER_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t                         state;
   logic [1:0]                     scl_s, sda_s;
   logic                           scl_f, sda_f, scl_fd, sda_fd;
   logic [FW-1:0]                  scl_cnt, sda_cnt;
   logic [2**MEM_AW-1:0][7:0]      mem;
   logic [MEM_AW-1:0]              ptr;
   logic [7:0]                     sh;
   logic [2:0]                     bit_cnt;
   logic                           ack_bit, rw, sda_low;
   logic                           scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]                     byte_in;

   // Release SDA combinationally on reset so no clock edge is needed.
   assign scl_pin    = 1'bz;
   assign sda_pin    = (sda_low && reset_n_i) ? 1'b0 : 1'bz;
   assign dbg_data_o = mem[dbg_addr_i];
   assign ptr_o      = ptr;

   assign scl_rise  = scl_f & ~scl_fd;
   assign scl_fall  = ~scl_f & scl_fd;
   assign start_det = scl_f & scl_fd & sda_fd & ~sda_f;
   assign stop_det  = scl_f & scl_fd & ~sda_fd & sda_f;
   assign byte_in   = {sh[6:0], sda_f};

   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         scl_s   <= '1;
         sda_s   <= '1;
         scl_f   <= 1'b1;
         sda_f   <= 1'b1;
         scl_fd  <= 1'b1;
         sda_fd  <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         scl_s  <= {scl_s[0], scl_pin};
         sda_s  <= {sda_s[0], sda_pin};
         scl_fd <= scl_f;
         sda_fd <= sda_f;
         if (scl_s[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == CNT_MAX) begin
            scl_f   <= scl_s[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
         if (sda_s[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == CNT_MAX) begin
            sda_f   <= sda_s[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state    <= IDLE;
         mem      <= '0;
         ptr      <= '0;
         sh       <= '0;
         bit_cnt  <= '0;
         ack_bit  <= 1'b0;
         rw       <= 1'b0;
         sda_low  <= 1'b0;
         busy_o   <= 1'b0;
         sel_o    <= 1'b0;
         wr_stb_o <= 1'b0;
      end else begin
         wr_stb_o <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            ack_bit <= 1'b0;
            sda_low <= 1'b0;
            sel_o   <= 1'b0;
            busy_o  <= 1'b1;
         end else if (stop_det) begin
            state   <= IDLE;
            ack_bit <= 1'b0;
            sda_low <= 1'b0;
            sel_o   <= 1'b0;
            busy_o  <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: if (scl_rise) begin
                  sh      <= byte_in;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        rw    <= sda_f;
                        state <= (sh[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                     end else if (state == PTR) begin
                        ptr   <= byte_in[MEM_AW-1:0];
                        state <= PTR_ACK;
                     end else begin
                        mem[ptr] <= byte_in;
                        wr_stb_o <= 1'b1;
                        ptr      <= ptr + 1'b1;
                        state    <= WDATA_ACK;
                     end
                  end
               end
               // ack_bit separates the fall that starts the ACK slot from the one that ends it
               ADDR_ACK: if (scl_fall) begin
                  if (!ack_bit) begin
                     sda_low <= 1'b1;
                     sel_o   <= 1'b1;
                     ack_bit <= 1'b1;
                  end else begin
                     ack_bit <= 1'b0;
                     bit_cnt <= '0;
                     if (rw) begin
                        sh      <= mem[ptr];
                        sda_low <= ~mem[ptr][7];
                        state   <= RDATA;
                     end else begin
                        sda_low <= 1'b0;
                        state   <= PTR;
                     end
                  end
               end
               PTR_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!ack_bit) begin
                     sda_low <= 1'b1;
                     ack_bit <= 1'b1;
                  end else begin
                     sda_low <= 1'b0;
                     ack_bit <= 1'b0;
                     bit_cnt <= '0;
                     state   <= WDATA;
                  end
               end
               RDATA: if (scl_rise) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= RDATA_ACK;
               end else if (scl_fall) begin
                  sh      <= {sh[6:0], 1'b0};
                  sda_low <= ~sh[6];
               end
               // pointer advances past every byte handed out, so a NACKed byte is not re-read
               RDATA_ACK: if (scl_rise) begin
                  ptr <= ptr + 1'b1;
                  if (sda_f) state <= IGNORE;
                  else ack_bit <= 1'b1;
               end else if (scl_fall) begin
                  if (ack_bit) begin
                     ack_bit <= 1'b0;
                     sh      <= mem[ptr];
                     sda_low <= ~mem[ptr][7];
                     state   <= RDATA;
                  end else begin
                     sda_low <= 1'b0;
                  end
               end
               default: sda_low <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a bit-banged open-drain master drives
// write, read, mismatch, wrap, glitch and mid-read reset sequences.
`timescale 1ns/1ps
module tb_i2c_slave_mem;
   localparam int Q = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl_low = 1'b0;
   logic       m_sda_low = 1'b0;
   logic [3:0] dbg_addr = '0;
   logic [7:0] dbg_data;
   logic       busy, sel, wr_stb;
   logic [3:0] ptr;
   wire        scl, sda;

   int checks = 0;
   int failures = 0;
   int stb_cnt = 0;
   logic mon_en = 1'b0, dut_drive_seen = 1'b0, sel_seen = 1'b0, busy_seen = 1'b0;

   assign scl = m_scl_low ? 1'b0 : 1'bz;
   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (scl);
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave_mem #(.SLAVE_ADDR(7'h50), .MEM_AW(4), .FILTER_LEN(3)) dut (
      .sysclk_i(clk), .reset_n_i(rst_n), .scl_pin(scl), .sda_pin(sda),
      .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .busy_o(busy),
      .sel_o(sel), .wr_stb_o(wr_stb), .ptr_o(ptr)
   );

   always @(negedge clk) begin
      if (wr_stb) stb_cnt++;
      if (mon_en) begin
         if (!m_sda_low && sda === 1'b0) dut_drive_seen = 1'b1;
         if (sel) sel_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; #Q;
      m_scl_low = 1'b0; #Q;
      m_sda_low = 1'b1; #Q;
      m_scl_low = 1'b1; #Q;
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; #Q;
      m_scl_low = 1'b0; #Q;
      m_sda_low = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = ~b[i];
         if (i == glitch_bit) begin
            #40; m_scl_low = 1'b0; #20; m_scl_low = 1'b1; #40;
         end else begin
            #Q;
         end
         m_scl_low = 1'b0; #(2*Q);
         m_scl_low = 1'b1; #Q;
      end
      m_sda_low = 1'b0; #Q;
      m_scl_low = 1'b0; #Q;
      ack = sda;        #Q;
      m_scl_low = 1'b1; #Q;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      m_sda_low = 1'b0;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         #Q; m_scl_low = 1'b0;
         #Q; b = {b[6:0], sda};
         #Q; m_scl_low = 1'b1;
         #Q;
      end
      m_sda_low = ~nack; #Q;
      m_scl_low = 1'b0;  #(2*Q);
      m_scl_low = 1'b1;
      m_sda_low = 1'b0;  #Q;
   endtask

   task automatic peek(input logic [3:0] a, output logic [7:0] d);
      dbg_addr = a; #1; d = dbg_data;
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd;
      #2;
      #50;
      check("rst_sda", sda, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_sel", sel, 1'b0);
      check("rst_stb", wr_stb, 1'b0);
      check("rst_ptr", ptr, 4'h0);
      peek(4'h3, rd); check("rst_mem3", rd, 8'h00);
      rst_n = 1'b1;
      #(2*Q);

      // write 0x51,0x52 from pointer 3
      stb_cnt = 0;
      bus_start();
      write_byte(8'hA0, -1, ack); check("wr_ack_addr", ack, 1'b0);
      check("wr_sel", sel, 1'b1);
      check("wr_busy", busy, 1'b1);
      write_byte(8'h03, -1, ack); check("wr_ack_ptr", ack, 1'b0);
      write_byte(8'h51, -1, ack); check("wr_ack_d0", ack, 1'b0);
      write_byte(8'h52, -1, ack); check("wr_ack_d1", ack, 1'b0);
      bus_stop(); #Q;
      peek(4'h3, rd); check("wr_mem3", rd, 8'h51);
      peek(4'h4, rd); check("wr_mem4", rd, 8'h52);
      check("wr_stb_cnt", stb_cnt, 2);
      check("wr_ptr", ptr, 4'h5);
      check("wr_idle_busy", busy, 1'b0);

      // read back with repeated start
      bus_start();
      write_byte(8'hA0, -1, ack); check("rd_ack_addr", ack, 1'b0);
      write_byte(8'h03, -1, ack); check("rd_ack_ptr", ack, 1'b0);
      bus_start();
      write_byte(8'hA1, -1, ack); check("rd_ack_addr_r", ack, 1'b0);
      read_byte(1'b0, rd); check("rd_b0", rd, 8'h51);
      read_byte(1'b1, rd); check("rd_b1", rd, 8'h52);
      bus_stop(); #Q;
      check("rd_ptr", ptr, 4'h5);
      check("rd_sel_after", sel, 1'b0);

      // address mismatch
      dut_drive_seen = 1'b0; sel_seen = 1'b0; busy_seen = 1'b0; stb_cnt = 0;
      mon_en = 1'b1;
      bus_start();
      write_byte(8'hA2, -1, ack); check("mm_ack_addr", ack, 1'b1);
      write_byte(8'h00, -1, ack); check("mm_ack_d0", ack, 1'b1);
      write_byte(8'hFF, -1, ack); check("mm_ack_d1", ack, 1'b1);
      bus_stop(); #Q;
      mon_en = 1'b0;
      check("mm_drive", dut_drive_seen, 1'b0);
      check("mm_sel", sel_seen, 1'b0);
      check("mm_busy", busy_seen, 1'b1);
      check("mm_busy_end", busy, 1'b0);
      check("mm_stb", stb_cnt, 0);
      peek(4'h0, rd); check("mm_mem0", rd, 8'h00);
      peek(4'h3, rd); check("mm_mem3", rd, 8'h51);

      // pointer wrap on write and read
      bus_start();
      write_byte(8'hA0, -1, ack); check("wp_ack_addr", ack, 1'b0);
      write_byte(8'h0F, -1, ack); check("wp_ack_ptr", ack, 1'b0);
      write_byte(8'hAA, -1, ack); check("wp_ack_d0", ack, 1'b0);
      write_byte(8'hBB, -1, ack); check("wp_ack_d1", ack, 1'b0);
      bus_stop(); #Q;
      peek(4'hF, rd); check("wp_mem15", rd, 8'hAA);
      peek(4'h0, rd); check("wp_mem0", rd, 8'hBB);
      check("wp_ptr", ptr, 4'h1);
      bus_start();
      write_byte(8'hA0, -1, ack);
      write_byte(8'h0F, -1, ack);
      bus_start();
      write_byte(8'hA1, -1, ack); check("wp_ack_rd", ack, 1'b0);
      read_byte(1'b0, rd); check("wp_rd0", rd, 8'hAA);
      read_byte(1'b1, rd); check("wp_rd1", rd, 8'hBB);
      bus_stop(); #Q;

      // glitch rejection: SDA on idle bus, then SCL mid-byte
      busy_seen = 1'b0; mon_en = 1'b1;
      m_sda_low = 1'b1; #20; m_sda_low = 1'b0; #(3*Q);
      mon_en = 1'b0;
      check("gl_sda_busy", busy_seen, 1'b0);
      bus_start();
      write_byte(8'hA0, -1, ack);
      write_byte(8'h07, -1, ack);
      write_byte(8'h5A, 3, ack); check("gl_ack", ack, 1'b0);
      bus_stop(); #Q;
      peek(4'h7, rd); check("gl_mem7", rd, 8'h5A);
      check("gl_ptr", ptr, 4'h8);

      // reset while the target drives a 0 data bit
      bus_start();
      write_byte(8'hA0, -1, ack);
      write_byte(8'h03, -1, ack);
      bus_start();
      write_byte(8'hA1, -1, ack);
      check("rr_driving", sda, 1'b0);
      rst_n = 1'b0; #1;
      check("rr_sda_rel", sda, 1'b1);
      check("rr_busy", busy, 1'b0);
      check("rr_sel", sel, 1'b0);
      check("rr_ptr", ptr, 4'h0);
      peek(4'h3, rd); check("rr_mem3", rd, 8'h00);
      #30; rst_n = 1'b1; #Q;
      bus_stop(); #Q;
      bus_start();
      write_byte(8'hA0, -1, ack); check("rr_ack_addr", ack, 1'b0);
      write_byte(8'h02, -1, ack); check("rr_ack_ptr", ack, 1'b0);
      write_byte(8'hC3, -1, ack); check("rr_ack_d0", ack, 1'b0);
      bus_stop(); #Q;
      peek(4'h2, rd); check("rr_mem2", rd, 8'hC3);
      check("rr_ptr_end", ptr, 4'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
